// File: rtl/cep_noc_serializer_if.sv
// Handshake bundle between CEP reassembly (package source), the serializer and the NoC injection port.
interface cep_noc_serializer_if #(
    parameter int NOC_WIDTH = 64
);
    localparam int CEP_DATA_WIDTH = 8 * NOC_WIDTH;

    logic                      cep_val;
    logic [CEP_DATA_WIDTH-1:0] cep_data;
    logic                      cep_rdy;
    logic                      noc_val;
    logic [NOC_WIDTH-1:0]      noc_data;
    logic                      noc_rdy;

    // master: package source plus NoC sink; slave: the serializer itself
    modport master (output cep_val, cep_data, noc_rdy, input cep_rdy, noc_val, noc_data);
    modport slave  (input cep_val, cep_data, noc_rdy, output cep_rdy, noc_val, noc_data);
endinterface

// File: rtl/cep_noc_serializer.sv
// Buffers one CEP package and replays it as a P-Mesh NoC message, one 64-bit flit per handshake.
// CEP word 0: [7:0] msg_type [15:8] mshrid [19:16] length [20] is_req [34:21] dst_chipid
//   [42:35] dst_x [50:43] dst_y [54:51] dst_fbits [56:55] mesi [58:57] subline_id [59] last_subline
// Request word 1: [47:0] addr [50:48] data_size [51] cache_type [55:52] subline_vector
// Request word 2: [13:0] src_chipid [21:14] src_x [29:22] src_y [33:30] src_fbits
module cep_noc_serializer #(
    parameter int NOC_WIDTH    = 64,
    parameter int MAX_REQ_LEN  = 7,
    parameter int MAX_RESP_LEN = 7
) (
    input  logic                clk,
    input  logic                rst,
    cep_noc_serializer_if.slave bus,
    output logic                len_err,
    output logic                busy
);
    localparam int         NWORDS   = 8;
    localparam logic [3:0] REQ_CAP  = 4'(MAX_REQ_LEN);
    localparam logic [3:0] RESP_CAP = 4'(MAX_RESP_LEN);

    typedef enum logic [2:0] {IDLE, HDR1, HDR2, HDR3, DATA} state_t;

    state_t               state, state_nxt;
    logic [NOC_WIDTH-1:0] buf_q [NWORDS];
    logic                 is_req_q;
    logic [2:0]           len_eff_q, ndata_q, cnt_q;
    logic                 len_err_q;

    logic       accept, noc_fire, last_flit;
    logic [3:0] in_len, in_cap, in_len_eff;
    logic       in_is_req, in_over;
    logic [2:0] in_ndata, word_idx;
    logic [NOC_WIDTH-1:0] hdr1, hdr2, hdr3;

    assign in_len     = bus.cep_data[19:16];
    assign in_is_req  = bus.cep_data[20];
    assign in_cap     = in_is_req ? REQ_CAP : RESP_CAP;
    assign in_over    = in_len > in_cap;
    assign in_len_eff = in_over ? in_cap : in_len;
    // Requests spend two length units on HDR2/HDR3; a shorter request carries no data at all.
    assign in_ndata   = !in_is_req ? in_len_eff[2:0]
                      : (in_len_eff < 4'd2) ? 3'd0 : 3'(in_len_eff - 4'd2);

    // noc_fire uses the registered state, keeping noc_val free of any input path.
    assign noc_fire  = (state != IDLE) && bus.noc_rdy;
    assign last_flit = (state == HDR1) ? (is_req_q ? (len_eff_q < 3'd2) : (len_eff_q == 3'd0))
                     : (state == HDR3) ? (ndata_q == 3'd0)
                     : (state == DATA) ? (cnt_q == ndata_q - 3'd1)
                     : 1'b0;
    assign accept    = bus.cep_val && bus.cep_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt; // NOTE: non-blocking so every flop samples pre-edge values.
        end
    end

    always_comb begin
        state_nxt = state; // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        if (state == IDLE) begin
            if (accept) state_nxt = HDR1;
        end else if (noc_fire) begin
            if (last_flit) begin
                state_nxt = accept ? HDR1 : IDLE;
            end else begin
                case (state)
                    HDR1:    state_nxt = is_req_q ? HDR2 : DATA;
                    HDR2:    state_nxt = HDR3;
                    HDR3:    state_nxt = DATA;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    assign bus.noc_val = (state != IDLE);
    assign busy        = (state != IDLE);
    assign bus.cep_rdy = (state == IDLE) || (noc_fire && last_flit);
    assign len_err     = len_err_q;

    assign word_idx = is_req_q ? (cnt_q + 3'd3) : (cnt_q + 3'd1);
    assign hdr1 = {buf_q[0][34:21], buf_q[0][42:35], buf_q[0][50:43], buf_q[0][54:51],
                   5'd0, len_eff_q, buf_q[0][7:0], buf_q[0][15:8],
                   1'b0, buf_q[0][56:55], buf_q[0][58:57], buf_q[0][59]};
    assign hdr2 = {buf_q[1][47:0], 8'd0, buf_q[1][50:48], buf_q[1][51], buf_q[1][55:52]};
    assign hdr3 = {buf_q[2][13:0], buf_q[2][21:14], buf_q[2][29:22], buf_q[2][33:30], 30'd0};

    always_comb begin
        bus.noc_data = '0;
        case (state)
            HDR1:    bus.noc_data = hdr1;
            HDR2:    bus.noc_data = hdr2;
            HDR3:    bus.noc_data = hdr3;
            DATA:    bus.noc_data = buf_q[word_idx];
            default: bus.noc_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the package buffer is cleared on reset so an aborted message leaves nothing behind.
            for (int i = 0; i < NWORDS; i++) buf_q[i] <= '0;
            is_req_q  <= 1'b0;
            len_eff_q <= '0;
            ndata_q   <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= accept && in_over;
            if (accept) begin
                for (int i = 0; i < NWORDS; i++) buf_q[i] <= bus.cep_data[i*NOC_WIDTH +: NOC_WIDTH];
                is_req_q  <= in_is_req;
                len_eff_q <= in_len_eff[2:0];
                ndata_q   <= in_ndata;
                cnt_q     <= '0;
            end else if (noc_fire && state == DATA) begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    // Header bits that are consumed at accept time or never forwarded.
    logic unused_bits;
    assign unused_bits = ^{buf_q[0][63:60], buf_q[0][20:16], buf_q[1][63:56], buf_q[2][63:34]};
endmodule

// File: doc/cep_noc_serializer.md
Name: cep_noc_serializer

Overview:
- Consumes one whole CEP package per valid/ready handshake and emits it as a P-Mesh NoC message, one 64-bit flit per cycle.
- Sits on the CEP receive path, directly after chip-link reassembly, and drives the on-chip NoC injection port.
- Requests carry 3 header flits plus up to 5 payload words; responses carry 1 header flit plus up to 7 payload words.

Parameters:
- NOC_WIDTH, 64: NoC flit width; must equal `CEP_WORD_WIDTH.
- MAX_REQ_LEN, 7: largest legal length field for a request (2 header flits + 5 data flits).
- MAX_RESP_LEN, 7: largest legal length field for a response (7 data flits).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cep_val  in  1  CEP package valid
- cep_data  in  `CEP_DATA_WIDTH  CEP package; fields are located with the `CEP_* macros in cep_defines.vh
- cep_rdy  out  1  package accepted when cep_val && cep_rdy
- noc_val  out  1  flit valid
- noc_data  out  NOC_WIDTH  flit
- noc_rdy  in  1  flit accepted when noc_val && noc_rdy
- len_err  out  1  one-cycle pulse: accepted package had an oversize length field
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, noc_val=0, len_err=0, busy=0, cep_rdy=1 from the first cycle after rst deasserts. noc_data is don't-care while noc_val=0.
- Package buffer: one entry holds the whole package. It is loaded on an accept and is never modified while busy.
- Ready rule: cep_rdy = (state==IDLE) || (the last flit handshakes this cycle). This allows zero-bubble back-to-back messages.
- Latency: package accepted in cycle t gives its first flit with noc_val=1 in cycle t+1.
- FSM states: IDLE, HDR1, HDR2, HDR3, DATA.
  - IDLE -> HDR1 on accept.
  - HDR1 -> HDR2 if is_req, else -> DATA. If the effective length is 0, HDR1 is the last flit.
  - HDR2 -> HDR3.
  - HDR3 -> DATA, or is the last flit if the effective length is 2.
  - DATA increments a data counter from 0 to ndata-1. The last flit goes to HDR1 if a new package is accepted in the same cycle, else to IDLE.
- All transitions occur only on a noc_val && noc_rdy handshake. With noc_rdy=0, noc_data and the state hold.
- HDR1 flit, P-Mesh header 1 layout:
  - dst_chipid, dst_x, dst_y, dst_fbits
  - length = effective length
  - msg_type, mshrid
  - options1 = {mesi, subline_id, last_subline}
- HDR2 flit: addr placed in the P-Mesh address field; options2 = {data_size, cache_type, subline_vector}.
- HDR3 flit: src_chipid, src_x, src_y, src_fbits; remaining bits 0.
- Effective length: len_eff = min(length, MAX_REQ_LEN or MAX_RESP_LEN, chosen by is_req).
  - If length exceeds the cap, len_err pulses in the cycle after the accept and the message is sent truncated to len_eff.
  - The header length field carries len_eff.
- Data count: ndata = len_eff-2 for requests, len_eff for responses.
  - A request with len_eff<2 is legal: ndata=0 and len_eff is sent unchanged. Only HDR1 is emitted, then the FSM goes to IDLE.
- Payload word mapping, data flit i (0-based), CEP word k = cep_data[(k+1)*64-1:k*64]:
  - Request: word 3+i.
  - Response: word 1+i.
- Reset mid-message: rst in any cycle aborts the message, drops any partial output, clears the buffer and returns to IDLE. No flit is emitted in the cycle after rst.
- noc_data and noc_val are driven from registered state and buffer only; there is no combinational path from noc_rdy or cep_* to noc_data or noc_val.
- Only cep_rdy depends combinationally on noc_rdy.

Test Plan:
- Response, length=3, words 1..3 = 0xA1,0xA2,0xA3, noc_rdy=1:
  - flits are HDR1 (length=3), 0xA1, 0xA2, 0xA3 in cycles t+1..t+4.
  - cep_rdy=1 in cycle t+4.
- Request, length=4, addr=0x12_3456_7840, src_x=2, src_y=1, words 3,4 = 0xB0,0xB1:
  - flits are HDR1, HDR2 carrying 0x12_3456_7840, HDR3 with x=2/y=1, 0xB0, 0xB1.
- Back-to-back: two response packages with length=1 held valid continuously produce 4 flits in 4 consecutive cycles with no gap.
- Backpressure: noc_rdy toggled 1,0,0,1,… during a request with length=7:
  - noc_data is stable while stalled.
  - All 8 flits arrive in order.
  - cep_rdy=0 until the last flit handshakes.
- Oversize response, length=9:
  - len_err pulses once.
  - header length=7.
  - exactly 8 flits are sent (words 1..7).
- rst asserted during the HDR3 flit of a request:
  - the next cycle has noc_val=0 and cep_rdy=1.
  - a new response with length=0 is then sent as a single HDR1 flit.
